// File: rtl/audio_pkg.sv
// Shared widths and FSM state encoding for the stereo gain-ramp block.
package audio_pkg;

    localparam int SAMPLE_W   = 24;
    localparam int GAIN_W     = 4;
    localparam int RAMP_CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL_L = 2'd1,
        MUL_R = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/audio_gain_ramp_mul.sv
// Sequential signed x unsigned multiplier, one multiplier bit per cycle, LSB first.
// It computes a * (b + 1): the accumulator is seeded with a, which supplies the +1
// term, so a B_W-bit gain code needs only B_W add cycles.
module mul_shift_add #(
    parameter int A_W = 24,
    parameter int B_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic signed [A_W-1:0] a_i,
    input  logic        [B_W-1:0] b_i,
    output logic                  done_o,
    output logic signed [A_W+B_W:0] prod_o
);

    localparam int P_W  = A_W + B_W + 1;
    localparam int CW   = $clog2(B_W + 1);
    localparam logic [CW-1:0] LAST = CW'(B_W - 1);

    logic signed [P_W-1:0] acc_q, mcand_q, prod_d;
    logic        [B_W-1:0] mplr_q;
    logic        [CW-1:0]  cnt_q;
    logic                  run_q;

    // Result of the current step; final product is valid in the cycle done_o is high.
    always_comb begin
        prod_d = acc_q + (mplr_q[0] ? mcand_q : '0);
    end

    assign prod_o = prod_d;
    assign done_o = run_q && (cnt_q == LAST);

    // Load on start (takes priority so a new operand pair can follow back-to-back),
    // otherwise shift-add one bit per cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else if (start_i) begin
            acc_q   <= P_W'(a_i);
            mcand_q <= P_W'(a_i);
            mplr_q  <= b_i;
            cnt_q   <= '0;
            run_q   <= 1'b1;
        end else if (run_q) begin
            acc_q   <= prod_d;
            mcand_q <= mcand_q <<< 1;
            mplr_q  <= mplr_q >> 1;
            cnt_q   <= cnt_q + CW'(1);
            if (done_o) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/audio_gain_ramp.sv
// Stereo sample scaler with a slow gain ramp toward a target code (or 0 on mute).
// One shared shift-add multiplier handles left then right; outputs update in DONE.
module audio_gain_ramp #(
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
    parameter int GAIN_W   = audio_pkg::GAIN_W,
    parameter int RAMP_DIV = 64
) (
    input  logic                       sys_clk,
    input  logic                       reset,
    input  logic                       sample_tick,
    input  logic signed [SAMPLE_W-1:0] in_left,
    input  logic signed [SAMPLE_W-1:0] in_right,
    input  logic        [GAIN_W-1:0]   gain_left,
    input  logic        [GAIN_W-1:0]   gain_right,
    input  logic                       mute,
    output logic signed [SAMPLE_W-1:0] out_left,
    output logic signed [SAMPLE_W-1:0] out_right,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       overrun,
    output logic        [GAIN_W-1:0]   cur_gain_left,
    output logic        [GAIN_W-1:0]   cur_gain_right
);
    import audio_pkg::*;

    localparam int PW = SAMPLE_W + GAIN_W + 1;
    localparam logic [RAMP_CNT_W-1:0] RAMP_LAST = RAMP_CNT_W'(RAMP_DIV - 1);

    state_e                     state_q;
    logic signed [SAMPLE_W-1:0] in_r_q, out_l_q, out_r_q;
    logic        [GAIN_W-1:0]   gain_l_q, gain_r_q, cur_l_q, cur_r_q;
    logic                       mute_q, valid_q, overrun_q;
    logic   [RAMP_CNT_W-1:0]    ramp_q;
    logic signed [PW-1:0]       prod_l_q, mul_prod;
    logic                       mul_start, mul_done;
    logic signed [SAMPLE_W-1:0] mul_a;
    logic        [GAIN_W-1:0]   mul_b, tgt_l, tgt_r;

    // Floor-shift the product back to sample scale; a muted channel at gain 0 is forced silent.
    function automatic logic signed [SAMPLE_W-1:0] scale(input logic signed [PW-1:0] p,
                                                         input logic zero);
        return zero ? '0 : SAMPLE_W'(p >>> GAIN_W);
    endfunction

    // Move one code toward the target, never more.
    function automatic logic [GAIN_W-1:0] step(input logic [GAIN_W-1:0] cur,
                                               input logic [GAIN_W-1:0] tgt);
        if (cur < tgt)      return cur + GAIN_W'(1);
        else if (cur > tgt) return cur - GAIN_W'(1);
        else                return cur;
    endfunction

    // Multiplier operand mux: left straight from the ports at the tick, right from the latch.
    always_comb begin
        mul_start = ((state_q == IDLE) && sample_tick) || ((state_q == MUL_L) && mul_done);
        mul_a     = (state_q == IDLE) ? in_left : in_r_q;
        mul_b     = (state_q == IDLE) ? cur_l_q : gain_r_q;
        tgt_l     = mute ? '0 : gain_left;
        tgt_r     = mute ? '0 : gain_right;
    end

    mul_shift_add #(
        .A_W (SAMPLE_W),
        .B_W (GAIN_W)
    ) u_mul (
        .clk_i   (sys_clk),
        .rst_ni  (reset),
        .start_i (mul_start),
        .a_i     (mul_a),
        .b_i     (mul_b),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    // Main FSM: latch at tick, multiply L then R, publish in DONE and advance the ramp.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            in_r_q    <= '0;
            gain_l_q  <= '0;
            gain_r_q  <= '0;
            mute_q    <= 1'b0;
            prod_l_q  <= '0;
            out_l_q   <= '0;
            out_r_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ramp_q    <= '0;
            cur_l_q   <= '0;
            cur_r_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            if (sample_tick && (state_q != IDLE)) overrun_q <= 1'b1;
            case (state_q)
                IDLE: if (sample_tick) begin
                    in_r_q   <= in_right;
                    gain_l_q <= cur_l_q;
                    gain_r_q <= cur_r_q;
                    mute_q   <= mute;
                    state_q  <= MUL_L;
                end
                MUL_L: if (mul_done) begin
                    prod_l_q <= mul_prod;
                    state_q  <= MUL_R;
                end
                MUL_R: if (mul_done) begin
                    out_l_q <= scale(prod_l_q, mute_q && (gain_l_q == '0));
                    out_r_q <= scale(mul_prod, mute_q && (gain_r_q == '0));
                    valid_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                    if (ramp_q == RAMP_LAST) begin
                        ramp_q  <= '0;
                        cur_l_q <= step(cur_l_q, tgt_l);
                        cur_r_q <= step(cur_r_q, tgt_r);
                    end else begin
                        ramp_q <= ramp_q + RAMP_CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_left       = out_l_q;
    assign out_right      = out_r_q;
    assign out_valid      = valid_q;
    assign busy           = (state_q != IDLE);
    assign overrun        = overrun_q;
    assign cur_gain_left  = cur_l_q;
    assign cur_gain_right = cur_r_q;

endmodule

// File: tb/tb_audio_gain_ramp.sv
// Directed bench: fade-in, exact timing, overrun, mute fade-out and mid-computation reset.
// u_dut runs RAMP_DIV=2, u_dut1 runs RAMP_DIV=1 on the same inputs.
module tb_audio_gain_ramp;

    localparam int SW = 24;
    localparam int GW = 4;

    logic                 sys_clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 sample_tick = 1'b0;
    logic                 mute = 1'b0;
    logic signed [SW-1:0] in_left = '0, in_right = '0;
    logic        [GW-1:0] gain_left = '0, gain_right = '0;

    logic signed [SW-1:0] out_left, out_right, o1_left, o1_right;
    logic                 out_valid, busy, overrun, o1_valid, o1_busy, o1_overrun;
    logic        [GW-1:0] cur_gain_left, cur_gain_right, o1_gain_l, o1_gain_r;

    int n_chk = 0;
    int n_err = 0;
    int nv;

    always #5 sys_clk = ~sys_clk;

    audio_gain_ramp #(.SAMPLE_W(SW), .GAIN_W(GW), .RAMP_DIV(2)) u_dut (
        .sys_clk(sys_clk), .reset(reset), .sample_tick(sample_tick),
        .in_left(in_left), .in_right(in_right), .gain_left(gain_left), .gain_right(gain_right),
        .mute(mute), .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
        .busy(busy), .overrun(overrun), .cur_gain_left(cur_gain_left), .cur_gain_right(cur_gain_right)
    );

    audio_gain_ramp #(.SAMPLE_W(SW), .GAIN_W(GW), .RAMP_DIV(1)) u_dut1 (
        .sys_clk(sys_clk), .reset(reset), .sample_tick(sample_tick),
        .in_left(in_left), .in_right(in_right), .gain_left(gain_left), .gain_right(gain_right),
        .mute(mute), .out_left(o1_left), .out_right(o1_right), .out_valid(o1_valid),
        .busy(o1_busy), .overrun(o1_overrun), .cur_gain_left(o1_gain_l), .cur_gain_right(o1_gain_r)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One tick, then 19 more cycles; counts out_valid pulses of u_dut.
    task automatic do_sample(output int cnt);
        @(posedge sys_clk); #1 sample_tick = 1'b1;
        @(posedge sys_clk); #1 sample_tick = 1'b0;
        cnt = 0;
        repeat (18) begin
            @(posedge sys_clk); #1;
            if (out_valid) cnt++;
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_out_l", out_left, 0);
        chk("rst_out_r", out_right, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_gain_l", cur_gain_left, 0);
        @(posedge sys_clk); #1 reset = 1'b1;

        // fade-in from gain 0 to 15, one step per two samples on u_dut
        gain_left = 4'd15; gain_right = 4'd15;
        in_left = 24'sh100000; in_right = -24'sh100000;
        for (int n = 1; n <= 31; n++) begin
            do_sample(nv);
            if (n == 1) begin
                chk("fade1_out_l", out_left, 32'sh10000);
                chk("fade1_out_r", out_right, -32'sh10000);
                chk("fade1_gain", cur_gain_left, 0);
                chk("fade1_nvalid", nv, 1);
            end
            if (n == 2)  chk("fade2_gain", cur_gain_left, 1);
            if (n == 3)  chk("fade3_out_l", out_left, 32'sh20000);
            if (n == 29) chk("fade29_gain", cur_gain_left, 14);
            if (n == 30) begin
                chk("fade30_out_l", out_left, 32'shF0000);
                chk("fade30_gain", cur_gain_left, 15);
            end
            if (n == 31) begin
                chk("fade31_out_l", out_left, 32'sh100000);
                chk("fade31_gain_r", cur_gain_right, 15);
                chk("fade31_dut1_gain", o1_gain_l, 15);
            end
        end

        // exact latency at full gain; inputs changed after the tick must not matter
        in_left = -24'sd1; in_right = 24'sh7FFFFF;
        @(posedge sys_clk); #1 sample_tick = 1'b1;
        @(posedge sys_clk); #1 sample_tick = 1'b0;
        in_left = 24'sd5; in_right = '0;
        repeat (7) @(posedge sys_clk);
        #1;
        chk("lat_t8_valid", out_valid, 0);
        chk("lat_t8_busy", busy, 1);
        @(posedge sys_clk); #1;
        chk("lat_t9_valid", out_valid, 1);
        chk("lat_t9_out_l", out_left, -32'sd1);
        chk("lat_t9_out_r", out_right, 32'sh7FFFFF);
        @(posedge sys_clk); #1;
        chk("lat_t10_valid", out_valid, 0);
        chk("lat_t10_busy", busy, 0);
        chk("lat_t10_hold_l", out_left, -32'sd1);

        // ticks while busy and in DONE are dropped
        chk("ovr_before", overrun, 0);
        in_left = 24'sh100000; in_right = '0;
        @(posedge sys_clk); #1 sample_tick = 1'b1;
        nv = 0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge sys_clk); #1;
            if (out_valid) nv++;
            if (i == 9) chk("ovr_done_cycle", out_valid, 1);
            sample_tick = (i == 3 || i == 9);
        end
        chk("ovr_nvalid", nv, 1);
        chk("ovr_flag", overrun, 1);
        chk("ovr_idle", busy, 0);

        // mute fade-out on u_dut1 (one step per sample)
        chk("mute_start_gain", o1_gain_l, 15);
        mute = 1'b1;
        in_left = 24'sh100000; in_right = -24'sh100000;
        for (int k = 1; k <= 17; k++) begin
            do_sample(nv);
            if (k == 1) begin
                chk("mute1_out_l", o1_left, 32'sh100000);
                chk("mute1_gain", o1_gain_l, 14);
            end
            if (k == 15) begin
                chk("mute15_out_l", o1_left, 32'sh20000);
                chk("mute15_out_r", o1_right, -32'sh20000);
            end
            if (k == 16) begin
                chk("mute16_out_l", o1_left, 0);
                chk("mute16_out_r", o1_right, 0);
            end
            if (k == 17) begin
                chk("mute17_out_l", o1_left, 0);
                chk("mute17_gain", o1_gain_l, 0);
            end
        end

        // reset in cycle T+5 of a computation
        in_left = 24'sh100000; in_right = 24'sh100000;
        @(posedge sys_clk); #1 sample_tick = 1'b1;
        @(posedge sys_clk); #1 sample_tick = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1 reset = 1'b0;
        #1;
        chk("mrst_out_l", out_left, 0);
        chk("mrst_out_r", out_right, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_gain_l", cur_gain_left, 0);
        chk("mrst_gain_r", cur_gain_right, 0);
        chk("mrst_overrun", overrun, 0);
        nv = 0;
        repeat (12) begin
            @(posedge sys_clk); #1;
            if (out_valid) nv++;
        end
        chk("mrst_no_valid", nv, 0);
        reset = 1'b1;

        // normal operation after release, gain 0: floor(-1/16) = -1, 16/16 = 1
        mute = 1'b0;
        in_left = -24'sd1; in_right = 24'sh10; gain_left = 4'd15;
        do_sample(nv);
        chk("post_nvalid", nv, 1);
        chk("post_out_l", out_left, -32'sd1);
        chk("post_out_r", out_right, 1);
        chk("post_gain_l", cur_gain_left, 0);
        chk("post_dut1_gain", o1_gain_l, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/audio_gain_ramp.md
AUDIO_GAIN_RAMP -- requirements
Module: audio_gain_ramp

Interface
REQ-001 The block SHALL take parameter SAMPLE_W, default 24: signed sample width.
REQ-002 The block SHALL take parameter GAIN_W, default 4: gain code width.
REQ-003 The block SHALL take parameter RAMP_DIV, default 64: completed samples between gain steps, legal range 1..1023.
REQ-004 Port sys_clk  in  1  is the single system clock; all state is clocked on its rising edge.
REQ-005 Port reset  in  1  is the reset: asynchronous, active-low.
REQ-006 Port sample_tick  in  1  is a one-cycle pulse requesting a new output sample pair.
REQ-007 Port in_left  in  SAMPLE_W signed  is the left generator sample.
REQ-008 Port in_right  in  SAMPLE_W signed  is the right generator sample.
REQ-009 Port gain_left  in  GAIN_W  is the left target gain code.
REQ-010 Port gain_right  in  GAIN_W  is the right target gain code.
REQ-011 Port mute  in  1  forces both target gains to 0 while high.
REQ-012 Port out_left  out  SAMPLE_W signed  is the scaled left sample, to the codec data_left input.
REQ-013 Port out_right  out  SAMPLE_W signed  is the scaled right sample, to the codec data_right input.
REQ-014 Port out_valid  out  1  pulses for one cycle when out_left and out_right update.
REQ-015 Port busy  out  1  is high whenever the FSM is not in IDLE.
REQ-016 Port overrun  out  1  is a sticky flag: a sample_tick was dropped.
REQ-017 Port cur_gain_left  out  GAIN_W  is the applied left gain, for LED display.
REQ-018 Port cur_gain_right  out  GAIN_W  is the applied right gain, for LED display.

Function
REQ-019 The FSM SHALL use four states: IDLE, MUL_L, MUL_R, DONE.
REQ-020 In IDLE, a sample_tick in cycle T SHALL latch in_left, in_right, cur_gain_left and cur_gain_right and move to MUL_L.
REQ-021 MUL_L SHALL take cycles T+1..T+4 and MUL_R cycles T+5..T+8, each a shift-add multiply at one gain bit per cycle, LSB first.
REQ-022 DONE SHALL occur in cycle T+9: outputs register, out_valid=1 for that cycle only, and the FSM returns to IDLE at T+10.
REQ-023 Scaling SHALL be out = (in * (g+1)) >>> GAIN_W: product width SAMPLE_W+GAIN_W+1 signed, arithmetic shift (floor), then low SAMPLE_W bits kept; with max gain 16/16 no overflow is possible.
REQ-024 Between out_valid pulses, out_left and out_right SHALL hold their values.
REQ-025 A sample_tick arriving when the FSM is not in IDLE (including DONE) SHALL be ignored and SHALL set overrun.
REQ-026 Samples and gains latched at T SHALL be used for the whole computation; input changes after T SHALL not affect it.
REQ-027 The ramp counter SHALL count DONE cycles from 0 to RAMP_DIV-1 and wrap to 0.
REQ-028 At wrap, each cur_gain SHALL step by exactly ±1 toward its effective target (0 if mute, else gain_x), and hold if equal; the new gain applies from the next sample.
REQ-029 When mute=1 and cur_gain=0 for a channel, that channel's output at DONE SHALL be exactly 0 instead of in>>>GAIN_W.
REQ-030 Target changes mid-ramp SHALL redirect the next step; no step SHALL ever exceed 1 code.

Reset
REQ-031 Reset SHALL abort any computation and force state=IDLE, out_left=out_right=0, out_valid=0, overrun=0, ramp counter=0.
REQ-032 Reset SHALL force cur_gain_left=cur_gain_right=0, so audio fades in from 1/16 after release.

Structure
REQ-033 SAMPLE_W, GAIN_W and the state enum typedef SHALL live in the shared package audio_pkg.
REQ-034 One sub-module, mul_shift_add (sequential signed × unsigned, start/done), SHALL be instantiated once and time-shared across both channels.

Verification
REQ-035 RAMP_DIV=2, gains start at 0, gain_left=15, in_left=24'sh100000, ticks every 20 cycles -> cur_gain_left reaches 15 after the 30th DONE, and out_left=24'sh100000 thereafter.
REQ-036 cur_gain=15, in_left=-1, in_right=24'sh7FFFFF -> out_left=-1 and out_right=24'sh7FFFFF exactly 9 cycles after the tick.
REQ-037 A tick while busy and a tick exactly in DONE -> both ignored, overrun=1, and out_valid count stays 1.
REQ-038 mute=1 with cur_gain=15 and RAMP_DIV=1 -> gain decrements by 1 per sample and output is 0 from the 16th sample on.
REQ-039 reset asserted in cycle T+5 of a computation -> outputs 0 immediately (asynchronously), no out_valid, cur_gain 0, and normal operation on the next tick after release.
